// File: rtl/frame_fifo.sv
// rtl/frame_fifo.sv - multi-channel frame FIFO with valid/ready handshakes, count and flush
// Optional sticky overflow/underflow flags when FRAME_FIFO_ERR_CHECK_EN is defined.
module frame_fifo #(
    parameter int ADDR_WIDTH = 3,
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 16,
    parameter int CHANNELS   = 6
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           wr_valid,
    output logic                           wr_ready,
    input  logic [CHANNELS*DATA_WIDTH-1:0] wr_data,
    output logic                           rd_valid,
    input  logic                           rd_ready,
    output logic [CHANNELS*DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH:0]            count,
    output logic [1:0]                     err
);
    localparam int FRAME_W = CHANNELS * DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR   = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [FRAME_W-1:0]    mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  wr_fire;
    logic                  rd_fire;

    // DEPTH need not be a power of two, so wrap on an explicit compare.
    function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign wr_ready = (count != FULL_COUNT);
    assign rd_valid = (count != '0);
    assign wr_fire  = wr_valid & wr_ready;
    assign rd_fire  = rd_valid & rd_ready;
    assign rd_data  = rd_valid ? mem[rd_ptr] : '1;

    always_ff @(posedge clk) begin
        if (wr_fire && !flush) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (rd_fire) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({wr_fire, rd_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef FRAME_FIFO_ERR_CHECK_EN
    logic [1:0] err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 2'b00;
        end else if (flush) begin
            err_q <= 2'b00;
        end else begin
            err_q <= err_q | {rd_ready & ~rd_valid, wr_valid & ~wr_ready};
        end
    end

    assign err = err_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst && wr_valid && !wr_ready) begin
            $display("FRAME_FIFO ERROR: overflow");
        end
        if (!rst && rd_ready && !rd_valid) begin
            $display("FRAME_FIFO ERROR: underflow");
        end
    end
`endif
`else
    assign err = 2'b00;
`endif

endmodule

// File: tb/tb_frame_fifo.sv
// tb/tb_frame_fifo.sv - randomized and directed check of frame_fifo (DEPTH 8 and DEPTH 6) against a queue model
module tb_frame_fifo;
    localparam int DW = 16;
    localparam int CH = 6;
    localparam int FW = DW * CH;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          wr_valid = 1'b0;
    logic          rd_ready = 1'b0;
    logic [FW-1:0] wr_data = '0;

    logic          wr_ready_a, rd_valid_a, wr_ready_b, rd_valid_b;
    logic [FW-1:0] rd_data_a, rd_data_b;
    logic [3:0]    count_a, count_b;
    logic [1:0]    err_a, err_b;

    int vectors = 0;
    int miscompares = 0;

    logic [FW-1:0] q [2][$];
    logic [1:0]    e [2];
    int            dep [2] = '{8, 6};

    always #5 clk = ~clk;

    frame_fifo #(.ADDR_WIDTH(3), .DEPTH(8), .DATA_WIDTH(DW), .CHANNELS(CH)) dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .wr_valid(wr_valid), .wr_ready(wr_ready_a), .wr_data(wr_data),
        .rd_valid(rd_valid_a), .rd_ready(rd_ready), .rd_data(rd_data_a),
        .count(count_a), .err(err_a)
    );

    frame_fifo #(.ADDR_WIDTH(3), .DEPTH(6), .DATA_WIDTH(DW), .CHANNELS(CH)) dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .wr_valid(wr_valid), .wr_ready(wr_ready_b), .wr_data(wr_data),
        .rd_valid(rd_valid_b), .rd_ready(rd_ready), .rd_data(rd_data_b),
        .count(count_b), .err(err_b)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [FW-1:0] pattern(input int n);
        logic [FW-1:0] f;
        for (int k = 0; k < CH; k++) f[k*DW +: DW] = 16'(16'h1000 * n + k);
        return f;
    endfunction

    function automatic logic [FW-1:0] rnd_frame();
        return {$urandom, $urandom, $urandom};
    endfunction

    function automatic logic [1:0] exp_err(input int i);
`ifdef FRAME_FIFO_ERR_CHECK_EN
        return e[i];
`else
        return 2'b00;
`endif
    endfunction

    task automatic compare_all();
        int n;
        n = q[0].size();
        check("a_count", count_a, n);
        check("a_wr_ready", wr_ready_a, n != 8);
        check("a_rd_valid", rd_valid_a, n != 0);
        check("a_rd_data", rd_data_a, (n != 0) ? q[0][0] : {FW{1'b1}});
        check("a_err", err_a, exp_err(0));
        n = q[1].size();
        check("b_count", count_b, n);
        check("b_wr_ready", wr_ready_b, n != 6);
        check("b_rd_valid", rd_valid_b, n != 0);
        check("b_rd_data", rd_data_b, (n != 0) ? q[1][0] : {FW{1'b1}});
        check("b_err", err_b, exp_err(1));
    endtask

    // One clock: apply inputs, check current state at the falling edge, then advance the model.
    task automatic cycle(input logic f, input logic wv, input logic [FW-1:0] wd, input logic rr);
        int n;
        flush = f; wr_valid = wv; wr_data = wd; rd_ready = rr;
        @(negedge clk);
        compare_all();
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            n = q[i].size();
            if (f) begin
                q[i].delete();
                e[i] = 2'b00;
            end else begin
                if (wv && n == dep[i]) e[i][0] = 1'b1;
                if (rr && n == 0) e[i][1] = 1'b1;
                if (rr && n > 0) void'(q[i].pop_front());
                if (wv && n < dep[i]) q[i].push_back(wd);
            end
        end
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 2; i++) begin
            q[i].delete();
            e[i] = 2'b00;
        end
    endtask

    task automatic async_reset();
        rst = 1'b1;
        clear_model();
        #2;
        compare_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [FW-1:0] fr;
        clear_model();
        @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;

        // fill with channel pattern, then full with simultaneous read
        for (int n = 0; n < 8; n++) cycle(0, 1, pattern(n), 0);
        cycle(0, 0, '0, 0);
        check("fill_count", count_a, 8);
        check("fill_wr_ready", wr_ready_a, 0);
        cycle(0, 1, pattern(9), 1);
        check("full_rw_count", count_a, 7);
        for (int n = 0; n < 9; n++) cycle(0, 0, '0, 1);
        check("drain_rd_valid", rd_valid_a, 0);

        // empty with same-cycle write and read request
        fr = rnd_frame();
        cycle(0, 1, fr, 1);
        check("empty_w_count", count_a, 1);
        check("empty_w_data", rd_data_a, fr);

        // reset mid-stream with count 5
        for (int n = 0; n < 4; n++) cycle(0, 1, rnd_frame(), 0);
        check("pre_reset_count", count_a, 5);
        async_reset();
        check("reset_count", count_a, 0);
        check("reset_rd_data", rd_data_a, {FW{1'b1}});

        // flush overriding a write
        for (int n = 0; n < 4; n++) cycle(0, 1, rnd_frame(), 0);
        cycle(1, 1, rnd_frame(), 0);
        check("flush_count", count_a, 0);
        fr = rnd_frame();
        cycle(0, 1, fr, 0);
        check("flush_next_data", rd_data_a, fr);
        cycle(0, 0, '0, 1);

        // steady state at count 3 across pointer wrap
        for (int n = 0; n < 3; n++) cycle(0, 1, rnd_frame(), 0);
        for (int n = 0; n < 20; n++) cycle(0, 1, rnd_frame(), 1);
        check("wrap_count_b", count_b, 3);

        // random traffic
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 299) == 0) async_reset();
            cycle($urandom_range(0, 63) == 0, $urandom_range(0, 99) < 60, rnd_frame(),
                  $urandom_range(0, 99) < 50);
        end
        cycle(0, 0, '0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
